// File: rtl/tlut_drain_pkg.sv
// Shared types and default geometry for the TLUT result drain.
// Module parameters default to the constants here; derived widths follow DIM_C.
package tlut_drain_pkg;

  localparam int DEF_DIM_A     = 2;
  localparam int DEF_DIM_C     = 3;
  localparam int DEF_ACC_WIDTH = 8;
  localparam int ROW_W         = $clog2(DEF_DIM_C);
  localparam int SUM_WIDTH     = DEF_ACC_WIDTH + $clog2(DEF_DIM_C);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [DEF_DIM_A-1:0][DEF_ACC_WIDTH-1:0] row_t;

endpackage

// File: rtl/tlut_result_drain_if.sv
// Row-beat stream and lane-sum result bundle between the drain and its consumer.
interface tlut_result_drain_if #(
  parameter int DIM_A     = tlut_drain_pkg::DEF_DIM_A,
  parameter int DIM_C     = tlut_drain_pkg::DEF_DIM_C,
  parameter int ACC_WIDTH = tlut_drain_pkg::DEF_ACC_WIDTH,
  parameter int SUM_WIDTH = ACC_WIDTH + $clog2(DIM_C)
);

  logic                                 out_valid;
  logic                                 out_ready;
  logic [DIM_A-1:0][ACC_WIDTH-1:0]      out_data;
  logic [$clog2(DIM_C)-1:0]             out_row;
  logic                                 out_last;
  logic                                 sum_valid;
  logic [DIM_A-1:0][SUM_WIDTH-1:0]      sum_data;

  modport master (
    output out_valid, out_data, out_row, out_last, sum_valid, sum_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_last, sum_valid, sum_data,
    output out_ready
  );

endinterface

// File: rtl/tlut_lane_sum.sv
// Per-lane unsigned column accumulators: clear on a new snapshot, add one row per accepted beat.
module tlut_lane_sum #(
  parameter int DIM_A     = tlut_drain_pkg::DEF_DIM_A,
  parameter int ACC_WIDTH = tlut_drain_pkg::DEF_ACC_WIDTH,
  parameter int SUM_WIDTH = tlut_drain_pkg::SUM_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clear,
  input  logic                            i_add_en,
  input  logic [DIM_A-1:0][ACC_WIDTH-1:0] i_add,
  output logic [DIM_A-1:0][SUM_WIDTH-1:0] o_sum
);

  logic [DIM_A-1:0][SUM_WIDTH-1:0] r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add_en) begin
      for (int a = 0; a < DIM_A; a++) begin
        r_sum[a] <= r_sum[a] + SUM_WIDTH'(i_add[a]);
      end
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/tlut_result_drain.sv
// Snapshots the SIMD cell's product matrix on rollover and streams it out row by row,
// then presents the per-lane column sums for one cycle.
module tlut_result_drain #(
  parameter int DIM_A     = tlut_drain_pkg::DEF_DIM_A,
  parameter int DIM_C     = tlut_drain_pkg::DEF_DIM_C,
  parameter int ACC_WIDTH = tlut_drain_pkg::DEF_ACC_WIDTH,
  parameter int SUM_WIDTH = ACC_WIDTH + $clog2(DIM_C)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       capture,
  input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] product_in,
  input  logic                                       clear_overrun,
  output logic                                       busy,
  output logic                                       overrun,
  tlut_result_drain_if.master                        drain
);

  import tlut_drain_pkg::*;

  localparam int               RB       = $clog2(DIM_C);
  localparam logic [RB-1:0]    LAST_ROW = RB'(DIM_C - 1);

  state_t                                     r_state;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] r_snap;
  logic [RB-1:0]                              r_row;
  logic                                       r_out_valid;
  logic                                       r_busy;
  logic                                       r_sum_valid;
  logic                                       r_overrun;

  logic                                       w_hs;
  logic                                       w_last;
  logic                                       w_take;
  logic [DIM_A-1:0][ACC_WIDTH-1:0]            w_row_data;
  logic [DIM_A-1:0][SUM_WIDTH-1:0]            w_sum;

  assign w_hs       = r_out_valid & drain.out_ready;
  assign w_last     = (r_row == LAST_ROW);
  // A capture is accepted in IDLE and in DONE; in DRAIN it only flags overrun.
  assign w_take     = capture & (r_state != DRAIN);
  assign w_row_data = r_snap[r_row];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (capture) begin
            r_snap      <= product_in;
            r_row       <= '0;
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_hs) begin
            if (w_last) begin
              r_row       <= '0;
              r_state     <= DONE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_sum_valid <= 1'b1;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        DONE: begin
          r_sum_valid <= 1'b0;
          if (capture) begin
            r_snap      <= product_in;
            r_row       <= '0;
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_sum_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (capture && (r_state == DRAIN)) begin
      r_overrun <= 1'b1;
    end else if (clear_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  tlut_lane_sum #(
    .DIM_A     (DIM_A),
    .ACC_WIDTH (ACC_WIDTH),
    .SUM_WIDTH (SUM_WIDTH)
  ) u_lane_sum (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_take),
    .i_add_en (w_hs),
    .i_add    (w_row_data),
    .o_sum    (w_sum)
  );

  assign drain.out_valid = r_out_valid;
  assign drain.out_data  = w_row_data;
  assign drain.out_row   = r_row;
  assign drain.out_last  = r_out_valid & w_last;
  assign drain.sum_valid = r_sum_valid;
  assign drain.sum_data  = w_sum;
  assign busy            = r_busy;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_tlut_result_drain.sv
// Directed and randomized bench for tlut_result_drain against a behavioural matrix/sum model.
module tb_tlut_result_drain;

  localparam int DA = 2;
  localparam int DC = 3;
  localparam int AW = 8;
  localparam int SW = 10;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic                            capture = 1'b0;
  logic                            clear_overrun = 1'b0;
  logic [DC-1:0][DA-1:0][AW-1:0]   product_in = '0;
  logic                            busy;
  logic                            overrun;

  tlut_result_drain_if #(.DIM_A(DA), .DIM_C(DC), .ACC_WIDTH(AW), .SUM_WIDTH(SW)) u_if ();

  tlut_result_drain #(.DIM_A(DA), .DIM_C(DC), .ACC_WIDTH(AW), .SUM_WIDTH(SW)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .capture       (capture),
    .product_in    (product_in),
    .clear_overrun (clear_overrun),
    .busy          (busy),
    .overrun       (overrun),
    .drain         (u_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 = waiting, 1 = streaming rows, 2 = presenting sums.
  int m_ph;
  int m_row;
  int m_ovr;
  int m_snap [DC][DA];
  int m_acc  [DA];
  int m_fin  [DA];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_row = 0; m_ovr = 0;
    for (int a = 0; a < DA; a++) begin m_acc[a] = 0; m_fin[a] = 0; end
    for (int r = 0; r < DC; r++) for (int a = 0; a < DA; a++) m_snap[r][a] = 0;
  endtask

  task automatic model_take();
    for (int a = 0; a < DA; a++) begin
      m_fin[a] = 0;
      m_acc[a] = 0;
      for (int r = 0; r < DC; r++) begin
        m_snap[r][a] = int'(product_in[r][a]);
        m_fin[a] += m_snap[r][a];
      end
    end
    m_row = 0;
    m_ph  = 1;
  endtask

  task automatic model_step();
    if (m_ph == 1 && capture) m_ovr = 1;
    else if (clear_overrun) m_ovr = 0;
    case (m_ph)
      0: if (capture) model_take();
      1: if (u_if.out_ready) begin
           for (int a = 0; a < DA; a++) m_acc[a] += m_snap[m_row][a];
           if (m_row == DC - 1) begin m_row = 0; m_ph = 2; end
           else m_row++;
         end
      default: if (capture) model_take(); else m_ph = 0;
    endcase
  endtask

  task automatic check_all();
    chk("out_valid", u_if.out_valid, (m_ph == 1));
    chk("busy", busy, (m_ph == 1));
    chk("sum_valid", u_if.sum_valid, (m_ph == 2));
    chk("overrun", overrun, m_ovr[0]);
    if (m_ph == 1) begin
      chk("out_row", u_if.out_row, m_row);
      chk("out_last", u_if.out_last, (m_row == DC - 1));
      for (int a = 0; a < DA; a++) chk("out_data", u_if.out_data[a], m_snap[m_row][a]);
    end
    for (int a = 0; a < DA; a++)
      chk("sum_data", u_if.sum_data[a], (m_ph == 2) ? m_fin[a] : m_acc[a]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  task automatic load(input int v0, v1, v2, v3, v4, v5);
    product_in[0][0] = AW'(v0); product_in[0][1] = AW'(v1);
    product_in[1][0] = AW'(v2); product_in[1][1] = AW'(v3);
    product_in[2][0] = AW'(v4); product_in[2][1] = AW'(v5);
  endtask

  task automatic pulse_capture();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (m_ph != 0 && n < budget) begin tick(); n++; end
    chk("drain_timeout", (m_ph != 0), 1'b0);
  endtask

  initial begin
    model_reset();
    u_if.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_out_row", u_if.out_row, 0);

    // Basic drain with ready held high
    load(1, 2, 3, 4, 5, 6);
    u_if.out_ready = 1'b1;
    pulse_capture();
    tick(); tick(); tick();
    chk("basic_sum0", u_if.sum_data[0], 9);
    chk("basic_sum1", u_if.sum_data[1], 12);
    run_until_idle(10);

    // Backpressure pattern
    begin
      logic [5:0] pat;
      pat = 6'b110100;
      u_if.out_ready = 1'b0;
      pulse_capture();
      for (int i = 0; i < 6; i++) begin
        u_if.out_ready = pat[i];
        tick();
      end
      u_if.out_ready = 1'b1;
      run_until_idle(10);
      chk("bp_sum0", u_if.sum_data[0], 9);
      chk("bp_sum1", u_if.sum_data[1], 12);
    end

    // Maximum element values
    load(255, 255, 255, 255, 255, 255);
    pulse_capture();
    run_until_idle(10);
    chk("max_sum0", u_if.sum_data[0], 765);
    chk("max_sum1", u_if.sum_data[1], 765);

    // Overrun: capture during row 1 with different data
    load(10, 20, 30, 40, 50, 60);
    pulse_capture();
    tick();
    load(99, 98, 97, 96, 95, 94);
    pulse_capture();
    chk("ovr_set", overrun, 1'b1);
    run_until_idle(10);
    chk("ovr_sum0", u_if.sum_data[0], 90);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr_cleared", overrun, 1'b0);
    u_if.out_ready = 1'b0;
    pulse_capture();
    capture = 1'b1; clear_overrun = 1'b1;
    tick();
    capture = 1'b0; clear_overrun = 1'b0;
    chk("ovr_setwins", overrun, 1'b1);
    u_if.out_ready = 1'b1;
    run_until_idle(10);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;

    // Back-to-back: capture in the sum cycle
    load(7, 8, 9, 10, 11, 12);
    pulse_capture();
    for (int i = 0; i < 10 && m_ph != 2; i++) tick();
    chk("b2b_sumv", u_if.sum_valid, 1'b1);
    load(1, 1, 2, 2, 3, 3);
    pulse_capture();
    chk("b2b_row0", u_if.out_data[0], 1);
    chk("b2b_novr", overrun, 1'b0);
    run_until_idle(10);

    // Reset mid-drain after the row 0 handshake
    pulse_capture();
    tick();
    rst = 1'b1;
    #1;
    chk("arst_valid", u_if.out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_sum0", u_if.sum_data[0], 0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    load(4, 5, 6, 7, 8, 9);
    pulse_capture();
    run_until_idle(10);
    chk("post_rst_sum1", u_if.sum_data[1], 21);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < DC; r++)
        for (int a = 0; a < DA; a++) product_in[r][a] = AW'($urandom_range(0, 255));
      capture        = ($urandom_range(0, 5) == 0);
      u_if.out_ready = $urandom_range(0, 1) == 1;
      clear_overrun  = ($urandom_range(0, 9) == 0);
      tick();
    end
    capture = 1'b0;
    clear_overrun = 1'b0;
    u_if.out_ready = 1'b1;
    run_until_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
